// File: rtl/test_resp_pkg.sv
// test_resp_pkg: shared widths, FSM state encoding and entry sizing for the response capture block.
package test_resp_pkg;
   localparam int RESP_W   = 9;
   localparam int TS_W_DEF = 16;
   localparam int ENTRY_W  = TS_W_DEF + RESP_W;
   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
   function automatic int entry_w(input int ts_w);
      return ts_w + RESP_W;
   endfunction
endpackage

// File: rtl/test_resp_fifo.sv
// test_resp_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data; ignored when full unless a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : oldest entry (zero when empty)
//   full, empty, level : occupancy status
module test_resp_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 25
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp, rp;
   logic         do_pop, do_push;
   assign do_pop  = pop & ~empty;
   // when full, a same-cycle pop frees the slot being written (the head is consumed this edge)
   assign do_push = push & (~full | do_pop);
   assign level   = wp - rp;
   assign empty   = wp == rp;
   assign full    = level == (AW+1)'(DEPTH);
   assign dout    = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/test_resp_capture.sv
// test_resp_capture: timestamps changes on nine upstream response lines and queues them in a FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   en                : capture enable (also gates the timestamp counter)
//   clr               : one-cycle pulse clearing overflow and drop_cnt
//   h..q              : response lines, h is the MSB of resp
//   out_valid/ready   : FIFO head handshake, out_data = {timestamp, resp}
//   level             : FIFO occupancy
//   overflow, drop_cnt: sticky drop flag and saturating drop count
module test_resp_capture import test_resp_pkg::*; #(
   parameter int DEPTH = 8,
   parameter int TS_W  = TS_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     h,
   input  logic                     i,
   input  logic                     j,
   input  logic                     l,
   input  logic                     m,
   input  logic                     n,
   input  logic                     o,
   input  logic                     p,
   input  logic                     q,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TS_W+RESP_W-1:0]   out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);
   localparam int EW = TS_W + RESP_W;
   state_t            state, state_nx;
   logic [TS_W-1:0]   ts, smp_ts;
   logic [RESP_W-1:0] smp_resp, prv_resp;
   logic              evt_vld, wr_evt, full, empty, pop, drop;
   logic [EW-1:0]     evt_data;
   always_comb begin
      state_nx = !en ? IDLE : (state == IDLE ? ARM : RUN);
      wr_evt   = state == ARM || (state == RUN && smp_resp != prv_resp);
   end
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign drop      = evt_vld & full & ~pop;
   // the event register adds one stage between detection and the FIFO write
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ts       <= '0;
         smp_ts   <= '0;
         smp_resp <= '0;
         prv_resp <= '0;
         evt_vld  <= 1'b0;
         evt_data <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nx;
         if (en) ts <= ts + 1'b1;
         smp_ts   <= ts;
         smp_resp <= {h, i, j, l, m, n, o, p, q};
         prv_resp <= smp_resp;
         evt_vld  <= wr_evt;
         evt_data <= {smp_ts, smp_resp};
         // a drop coinciding with clr counts as the first drop after the clear
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clr ? 8'd1 : drop_cnt + {7'd0, drop_cnt != 8'hFF};
         end else if (clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end
   test_resp_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (evt_vld),
      .pop   (out_ready),
      .din   (evt_data),
      .dout  (out_data),
      .full  (full),
      .empty (empty),
      .level (level)
   );
endmodule

// File: tb/tb_test_resp_capture.sv
// tb_test_resp_capture: directed stimulus, queue-based reference model and per-cycle output comparison.
module tb_test_resp_capture;
   localparam int DEPTH = 8;
   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, out_ready = 1'b0;
   logic [8:0]  r = '0;
   logic        out_valid, overflow;
   logic [24:0] out_data;
   logic [3:0]  level;
   logic [7:0]  drop_cnt;
   int          checks = 0, errors = 0;
   bit          started = 0;
   logic [24:0] mq[$];
   logic        m_ov;
   logic [7:0]  m_dc;
   logic [15:0] ts_m;
   logic [8:0]  last;
   int          mode;
   logic        pa_v, pb_v;
   logic [24:0] pa_d, pb_d;

   test_resp_capture #(.DEPTH(DEPTH), .TS_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .h(r[8]), .i(r[7]), .j(r[6]), .l(r[5]), .m(r[4]), .n(r[3]), .o(r[2]), .p(r[1]), .q(r[0]),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference model: mode 0=idle 1=arm 2=run. An event recognised at an edge enters the FIFO two edges later.
   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         mq.delete();
         m_ov = 0; m_dc = 0; ts_m = 0; last = 0; mode = 0;
         pa_v = 0; pb_v = 0; pa_d = 0; pb_d = 0;
      end else begin : mdl
         bit pop_m, drop_m;
         int nmode;
         pop_m = mq.size() != 0 && out_ready;
         if (pop_m) void'(mq.pop_front());
         drop_m = 0;
         if (pb_v) begin
            if (mq.size() < DEPTH) mq.push_back(pb_d);
            else drop_m = 1;
         end
         if (drop_m) begin
            m_ov = 1;
            m_dc = clr ? 8'd1 : (m_dc == 8'd255 ? 8'd255 : m_dc + 8'd1);
         end else if (clr) begin
            m_ov = 0; m_dc = 0;
         end
         pb_v = pa_v; pb_d = pa_d;
         nmode = !en ? 0 : (mode == 0 ? 1 : 2);
         pa_v = nmode == 1 || (nmode == 2 && r != last);
         pa_d = {ts_m, r};
         last = r;
         if (en) ts_m = ts_m + 16'd1;
         mode = nmode;
      end
   end

   always @(negedge clk) if (started) begin
      chk("out_valid", out_valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ov);
      chk("drop_cnt", drop_cnt, m_dc);
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
   end

   initial begin
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", level, 0);
      tick();
      rst = 0; en = 1;
      tick(); chk("arm_lat_e0", out_valid, 0);
      tick(); chk("arm_lat_e1", out_valid, 0);
      tick(); chk("arm_valid", out_valid, 1);
      chk("arm_entry", out_data, {16'd0, 9'h000});
      out_ready = 1;
      tick(); tick();
      r = 9'h100;
      tick(); chk("h_lat_e0", out_valid, 0);
      tick(); chk("h_lat_e1", out_valid, 0);
      tick(); chk("h_entry", out_data, {16'd5, 9'h100});
      tick();
      out_ready = 0;
      for (int k = 1; k <= 9; k++) begin
         r = 9'(k);
         tick();
      end
      repeat (3) tick();
      chk("fill_level", level, 8);
      chk("fill_ovf", overflow, 1);
      chk("fill_drop", drop_cnt, 1);
      clr = 1; tick(); clr = 0;
      chk("clr_ovf", overflow, 0);
      chk("clr_drop", drop_cnt, 0);
      out_ready = 1;
      for (int k = 1; k <= 8; k++) begin
         chk("drain_order", out_data[8:0], 9'(k));
         tick();
      end
      chk("drain_empty", out_valid, 0);
      out_ready = 0;
      for (int k = 0; k < 8; k++) begin
         r = 9'(9'h020 + k);
         tick();
      end
      repeat (3) tick();
      chk("full2_level", level, 8);
      r = 9'h030; tick(); tick();
      out_ready = 1; tick(); out_ready = 0;
      chk("coinc_level", level, 8);
      chk("coinc_ovf", overflow, 0);
      r = 9'h031; tick(); tick();
      clr = 1; tick(); clr = 0;
      chk("clrdrop_ovf", overflow, 1);
      chk("clrdrop_cnt", drop_cnt, 1);
      out_ready = 1;
      repeat (10) tick();
      for (int c = 0; c < 70000 && ts_m != 16'hFFFE; c++) tick();
      chk("ts_reach", ts_m, 16'hFFFE);
      out_ready = 0;
      tick(); r = 9'h055;
      tick(); r = 9'h0AA;
      repeat (3) tick();
      chk("wrap_level", level, 2);
      chk("wrap_first", out_data, {16'hFFFF, 9'h055});
      en = 0;
      repeat (4) tick();
      chk("hold_level", level, 2);
      chk("hold_data", out_data, {16'hFFFF, 9'h055});
      out_ready = 1; tick();
      chk("wrap_second", out_data, {16'h0000, 9'h0AA});
      tick();
      chk("wrap_empty", out_valid, 0);
      en = 1;
      repeat (4) tick();
      out_ready = 0;
      for (int k = 0; k < 270; k++) begin
         r = 9'(k + 256);
         tick();
      end
      repeat (3) tick();
      chk("sat_drop", drop_cnt, 255);
      chk("sat_level", level, 8);
      out_ready = 1;
      repeat (10) tick();
      out_ready = 0;
      for (int k = 0; k < 5; k++) begin
         r = 9'(9'h1F0 + k);
         tick();
      end
      repeat (3) tick();
      chk("pre_rst_level", level, 5);
      chk("pre_rst_ovf", overflow, 1);
      rst = 1; clr = 1; out_ready = 1; r = 9'h0F0;
      tick();
      rst = 0; clr = 0; out_ready = 0;
      chk("post_rst_level", level, 0);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ovf", overflow, 0);
      chk("post_rst_drop", drop_cnt, 0);
      repeat (6) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/test_resp_capture.md
TEST_RESP_CAPTURE -- requirements
Module: test_resp_capture

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 Parameter: TS_W, default 16, timestamp width.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  capture enable.
REQ-006 Port: clr  input  1  one-cycle pulse, clears overflow flag and drop count.
REQ-007 Port: h,i,j,l,m,n,o,p,q  input  1 each  response outputs of the upstream test block.
REQ-008 Port: out_valid  output  1  FIFO head holds a valid entry.
REQ-009 Port: out_ready  input  1  consumer accepts head this cycle.
REQ-010 Port: out_data  output  TS_W+9  {timestamp, resp}; resp = {h,i,j,l,m,n,o,p,q}, h is MSB.
REQ-011 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 Port: overflow  output  1  sticky: an event was dropped.
REQ-013 Port: drop_cnt  output  8  saturating count of dropped events.

Function
REQ-014 Sample stage: resp and current timestamp registered together every cycle (smp_resp, smp_ts).
REQ-015 Timestamp counter: +1 every cycle while en=1, holds while en=0, wraps 2^TS_W-1 -> 0.
REQ-016 FSM states: IDLE, ARM, RUN.
REQ-017 IDLE -> ARM when en=1; ARM -> RUN unconditionally next cycle; ARM or RUN -> IDLE when en=0.
REQ-018 ARM: writes one event {smp_ts, smp_resp} unconditionally (initial snapshot).
REQ-019 RUN: writes an event only when smp_resp differs from the previously sampled resp.
REQ-020 IDLE: no writes; samples still update so RUN comparison starts from current values.
REQ-021 Latency: input change ahead of edge k appears on out_valid/out_data after edge k+2 (FIFO empty).
REQ-022 Event with FIFO full and no simultaneous pop: dropped, overflow set, drop_cnt +1 saturating at 255.
REQ-023 Event with FIFO full and simultaneous pop (out_valid & out_ready): accepted, no drop.
REQ-024 FIFO first-word-fall-through; out_data equals oldest entry whenever out_valid=1.
REQ-025 out_valid & !out_ready: out_data and out_valid held stable.
REQ-026 Pop with FIFO empty impossible; out_ready ignored when out_valid=0.
REQ-027 clr: overflow and drop_cnt to 0 next cycle; a drop in the same cycle wins (overflow=1, drop_cnt=1).
REQ-028 en deasserted mid-run: FIFO contents retained and drainable; timestamp held.
REQ-029 level = writes minus pops, range 0..DEPTH, never exceeds DEPTH.

Reset
REQ-030 On rst=1 at clock edge: FSM=IDLE, timestamp=0, FIFO emptied, level=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0, sample regs=0.
REQ-031 rst overrides en, clr, out_ready in the same cycle; pending entries discarded.

Structure
REQ-032 Package test_resp_pkg holds RESP_W=9, TS_W default, FSM state enum, entry width.
REQ-033 One sub-module test_resp_fifo (synchronous FWFT FIFO, push/pop/full/empty/level); capture, FSM, counters in top.

Verification
REQ-034 Reset then en=1 with all inputs 0 -> one entry {ts=0, resp=9'h000}, out_valid after edge 2.
REQ-035 RUN, h toggles 0->1 at ts=5, out_ready=1 -> entry {5, 9'h100}; no entry while inputs stable.
REQ-036 out_ready=0, 9 distinct changes, DEPTH=8 -> level=8, overflow=1, drop_cnt=1; drain returns 8 entries in order.
REQ-037 FIFO full, change coincident with pop -> level stays 8, overflow stays 0.
REQ-038 Timestamp preloaded to 16'hFFFE, changes at two consecutive cycles -> entries ts=16'hFFFF then 16'h0000.
REQ-039 rst asserted with level=5 -> next cycle level=0, out_valid=0, overflow=0.
